behave_adder: RTL and testbench
===============================

// Module: behave_adder
// PURPOSE
//  - Lane-wise half adder: per bit, sum s = a ^ b, carry c = a & b.
//  - Optional output register stage and a valid qualifier.
//  - Saturating operation/carry counters for bring-up and debug.
//  - Leaf arithmetic primitive; sits under datapath blocks that need
//    bitwise sum/carry generation without carry propagation.
// PARAMETERS
//  - WIDTH      1   number of independent half-adder lanes (>=1)
//  - REGISTERED 1   1: s/c/out_valid registered (latency 1); 0: combinational
//  - CNT_W      16  width of ops_count and carry_count
// PORTS
//  - clk          in   1      single clock, all state updates on rising edge
//  - rst          in   1      reset, synchronous, active-high
//  - in_valid     in   1      a/b carry a valid operation this cycle
//  - a            in   WIDTH  operand A, one bit per lane
//  - b            in   WIDTH  operand B, one bit per lane
//  - out_valid    out  1      s/c hold the result of an accepted operation
//  - s            out  WIDTH  per-lane sum, a[i] ^ b[i]
//  - c            out  WIDTH  per-lane carry, a[i] & b[i]
//  - ops_count    out  CNT_W  accepted operations, saturating
//  - carry_count  out  CNT_W  accepted ops with any c bit set, saturating
// BEHAVIOUR
//  - Lanes are independent. No carry passes from lane i to lane i+1.
//  - REGISTERED=1:
//    - On an edge with in_valid=1: s<=a^b, c<=a&b, out_valid<=1.
//    - On an edge with in_valid=0: out_valid<=0; s/c hold their last value.
//  - REGISTERED=0:
//    - s=a^b and c=a&b continuously, whether in_valid is high or low.
//    - out_valid=in_valid. rst does not affect s/c/out_valid.
//  - Counters (both modes):
//    - ops_count increments by 1 on each edge with in_valid=1.
//    - carry_count increments when in_valid=1 and |(a&b)=1.
//    - Each counter saturates at all-ones and never wraps.
//  - Reset (rst=1 at a rising edge):
//    - s=0, c=0, out_valid=0 in registered mode.
//    - ops_count=0, carry_count=0.
//    - rst has priority over in_valid in the same cycle.
//    - An in-flight operation is discarded; no output appears for it.
//  - No backpressure: every in_valid cycle is accepted.
//  - X on a/b while in_valid=0 must not disturb registered state.
// TESTING
//  - Truth table, WIDTH=1, REGISTERED=1: (a,b)=00,01,10,11 on consecutive
//    valid cycles -> one cycle later (s,c)=00,10,10,01; out_valid=1.
//  - Reset: assert rst with in_valid=1, a=b=1 -> next edge s=0, c=0,
//    out_valid=0, both counters 0.
//  - Hold: in_valid=1 a=1 b=0, then in_valid=0 a=1 b=1 -> s=1 c=0 held,
//    out_valid drops to 0, ops_count=1.
//  - Lanes, WIDTH=4: a=4'b1100, b=4'b1010 -> s=4'b0110, c=4'b1000,
//    carry_count increments by 1.
//  - Saturation, CNT_W=4: 20 valid ops with a=b=1 -> ops_count=15 and
//    carry_count=15, no wrap.
//  - REGISTERED=0: apply a=1 b=1 -> s=0 c=1 in the same cycle, no clock edge.

Source files
------------

// File: rtl/behave_adder.sv
// Purpose: lane-wise half adder (s = a ^ b, c = a & b) with valid qualifier and saturating debug counters.
// Latency: 1 cycle when REGISTERED=1, 0 cycles (combinational s/c/out_valid) when REGISTERED=0.
// Backpressure: none; every in_valid cycle is accepted and counted.
module behave_adder #(
  parameter int WIDTH      = 1,
  parameter bit REGISTERED = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic [CNT_W-1:0] ops_count,
  output logic [CNT_W-1:0] carry_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Per-lane results; lanes are independent, no carry ripples between them.
  logic [WIDTH-1:0] sum_lanes;
  logic [WIDTH-1:0] carry_lanes;
  logic             any_carry;

  // Bitwise half-adder generation for all lanes at once.
  always_comb begin
    sum_lanes   = a ^ b;
    carry_lanes = a & b;
    any_carry   = |carry_lanes;
  end

  generate
    if (REGISTERED) begin : g_reg
      // Output stage: capture only on valid so s/c hold (and ignore X on a/b) when idle.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          s         <= '0;
          c         <= '0;
        end else begin
          out_valid <= in_valid;
          if (in_valid) begin
            s <= sum_lanes;
            c <= carry_lanes;
          end
        end
      end
    end else begin : g_comb
      // Pass-through: results follow a/b continuously, reset has no effect here.
      always_comb begin
        out_valid = in_valid;
        s         = sum_lanes;
        c         = carry_lanes;
      end
    end
  endgenerate

  // Accepted-operation counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_count <= '0;
    end else if (in_valid && (ops_count != CNT_MAX)) begin
      ops_count <= ops_count + CNT_ONE;
    end
  end

  // Counts accepted operations producing at least one carry, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_count <= '0;
    end else if (in_valid && any_carry && (carry_count != CNT_MAX)) begin
      carry_count <= carry_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_behave_adder.sv
// Purpose: directed self-checking bench for behave_adder in three configurations.
// Latency: registered instances checked 1 cycle after the launching edge, combinational one before any edge.
// Backpressure: none exercised; every valid cycle is expected to be accepted.
module tb_behave_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a4;
  logic [3:0] b4;

  // WIDTH=1, registered, default 16-bit counters
  logic        w1_ov;
  logic [0:0]  w1_s, w1_c;
  logic [15:0] w1_ops, w1_cry;
  // WIDTH=4, registered, 4-bit counters
  logic        w4_ov;
  logic [3:0]  w4_s, w4_c;
  logic [3:0]  w4_ops, w4_cry;
  // WIDTH=4, combinational
  logic        cb_ov;
  logic [3:0]  cb_s, cb_c;
  logic [15:0] cb_ops, cb_cry;

  int checks = 0;
  int errors = 0;

  behave_adder #(.WIDTH(1), .REGISTERED(1'b1), .CNT_W(16)) dut_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4[0:0]), .b(b4[0:0]),
    .out_valid(w1_ov), .s(w1_s), .c(w1_c), .ops_count(w1_ops), .carry_count(w1_cry)
  );

  behave_adder #(.WIDTH(4), .REGISTERED(1'b1), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4),
    .out_valid(w4_ov), .s(w4_s), .c(w4_c), .ops_count(w4_ops), .carry_count(w4_cry)
  );

  behave_adder #(.WIDTH(4), .REGISTERED(1'b0), .CNT_W(16)) dut_cb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4),
    .out_valid(cb_ov), .s(cb_s), .c(cb_c), .ops_count(cb_ops), .carry_count(cb_cry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus at the falling edge, then sample 1 time unit after the rising edge.
  task automatic cycle(input logic r, input logic v, input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    rst = r; in_valid = v; a4 = av; b4 = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 4'b0, 4'b0);
    cycle(1'b0, 1'b0, 4'b0, 4'b0);
  endtask

  task automatic test_reset();
    // rst together with a valid a=b=1 operation: reset wins, nothing is emitted or counted
    cycle(1'b1, 1'b1, 4'b1111, 4'b1111);
    checks++;
    if ({w1_ov, w1_s, w1_c} !== 3'b000) begin
      errors++; $display("FAIL reset_w1_out: got ov/s/c=%b required 000", {w1_ov, w1_s, w1_c});
    end
    checks++;
    if ({w1_ops, w1_cry} !== 32'd0) begin
      errors++; $display("FAIL reset_w1_cnt: got ops=%0d carry=%0d required 0/0", w1_ops, w1_cry);
    end
    checks++;
    if ({w4_ov, w4_s, w4_c, w4_ops, w4_cry} !== 17'd0) begin
      errors++; $display("FAIL reset_w4: got ov=%b s=%b c=%b ops=%0d carry=%0d required all 0",
                         w4_ov, w4_s, w4_c, w4_ops, w4_cry);
    end
  endtask

  task automatic test_truth_table();
    logic [3:0] av_tab;
    logic [3:0] bv_tab;
    logic [3:0] s_tab;
    logic [3:0] c_tab;
    av_tab = 4'b1100;  // index i -> a for (a,b)=00,01,10,11
    bv_tab = 4'b1010;
    s_tab  = 4'b0110;
    c_tab  = 4'b1000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, {3'b0, av_tab[i]}, {3'b0, bv_tab[i]});
      checks++;
      if ({w1_ov, w1_s, w1_c} !== {1'b1, s_tab[i], c_tab[i]}) begin
        errors++; $display("FAIL truth_%0d: got ov/s/c=%b required %b", i,
                           {w1_ov, w1_s, w1_c}, {1'b1, s_tab[i], c_tab[i]});
      end
    end
    checks++;
    if (w1_ops !== 16'd4 || w1_cry !== 16'd1) begin
      errors++; $display("FAIL truth_counts: got ops=%0d carry=%0d required 4/1", w1_ops, w1_cry);
    end
  endtask

  task automatic test_hold();
    do_reset();
    cycle(1'b0, 1'b1, 4'b0001, 4'b0000);
    cycle(1'b0, 1'b0, 4'b0001, 4'b0001);
    checks++;
    if ({w1_ov, w1_s, w1_c} !== 3'b010) begin
      errors++; $display("FAIL hold_out: got ov/s/c=%b required 010", {w1_ov, w1_s, w1_c});
    end
    checks++;
    if (w1_ops !== 16'd1 || w1_cry !== 16'd0) begin
      errors++; $display("FAIL hold_cnt: got ops=%0d carry=%0d required 1/0", w1_ops, w1_cry);
    end
    // Unknown operands while idle must leave registered state untouched
    cycle(1'b0, 1'b0, 4'bxxxx, 4'bxxxx);
    checks++;
    if ({w1_ov, w1_s, w1_c, w1_ops, w1_cry} !== {3'b010, 16'd1, 16'd0}) begin
      errors++; $display("FAIL hold_x: got ov/s/c=%b ops=%0d carry=%0d required 010/1/0",
                         {w1_ov, w1_s, w1_c}, w1_ops, w1_cry);
    end
  endtask

  task automatic test_lanes();
    do_reset();
    cycle(1'b0, 1'b1, 4'b1100, 4'b1010);
    checks++;
    if ({w4_ov, w4_s, w4_c} !== {1'b1, 4'b0110, 4'b1000}) begin
      errors++; $display("FAIL lanes_out: got ov=%b s=%b c=%b required 1/0110/1000", w4_ov, w4_s, w4_c);
    end
    checks++;
    if (w4_ops !== 4'd1 || w4_cry !== 4'd1) begin
      errors++; $display("FAIL lanes_cnt: got ops=%0d carry=%0d required 1/1", w4_ops, w4_cry);
    end
    // Back-to-back op without any carry: carry_count must not move
    cycle(1'b0, 1'b1, 4'b0101, 4'b1010);
    checks++;
    if ({w4_ov, w4_s, w4_c, w4_ops, w4_cry} !== {1'b1, 4'b1111, 4'b0000, 4'd2, 4'd1}) begin
      errors++; $display("FAIL lanes_nocarry: got ov=%b s=%b c=%b ops=%0d carry=%0d required 1/1111/0000/2/1",
                         w4_ov, w4_s, w4_c, w4_ops, w4_cry);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 4'b1111, 4'b1111);
    checks++;
    if (w4_ops !== 4'd15 || w4_cry !== 4'd15) begin
      errors++; $display("FAIL sat_at_max: got ops=%0d carry=%0d required 15/15", w4_ops, w4_cry);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'b1111, 4'b1111);
    checks++;
    if (w4_ops !== 4'd15 || w4_cry !== 4'd15) begin
      errors++; $display("FAIL sat_nowrap: got ops=%0d carry=%0d required 15/15", w4_ops, w4_cry);
    end
    checks++;
    if (w1_ops !== 16'd20 || w1_cry !== 16'd20) begin
      errors++; $display("FAIL sat_wide: got ops=%0d carry=%0d required 20/20", w1_ops, w1_cry);
    end
  endtask

  task automatic test_comb();
    do_reset();
    // No clock edge between drive and sample: result must appear combinationally
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; a4 = 4'b0001; b4 = 4'b0001;
    #1;
    checks++;
    if ({cb_ov, cb_s, cb_c} !== {1'b0, 4'b0000, 4'b0001}) begin
      errors++; $display("FAIL comb_idle: got ov=%b s=%b c=%b required 0/0000/0001", cb_ov, cb_s, cb_c);
    end
    in_valid = 1'b1; a4 = 4'b0110; b4 = 4'b0011;
    #1;
    checks++;
    if ({cb_ov, cb_s, cb_c} !== {1'b1, 4'b0101, 4'b0010}) begin
      errors++; $display("FAIL comb_valid: got ov=%b s=%b c=%b required 1/0101/0010", cb_ov, cb_s, cb_c);
    end
    // rst must not touch combinational outputs
    rst = 1'b1;
    #1;
    checks++;
    if ({cb_ov, cb_s, cb_c} !== {1'b1, 4'b0101, 4'b0010}) begin
      errors++; $display("FAIL comb_rst: got ov=%b s=%b c=%b required 1/0101/0010", cb_ov, cb_s, cb_c);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cb_ops !== 16'd1 || cb_cry !== 16'd1) begin
      errors++; $display("FAIL comb_cnt: got ops=%0d carry=%0d required 1/1", cb_ops, cb_cry);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a4 = 4'b0; b4 = 4'b0;
    test_reset();
    test_truth_table();
    test_hold();
    test_lanes();
    test_saturation();
    test_comb();
    cycle(1'b0, 1'b0, 4'b0, 4'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
